// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot / program-load sequencer.
// Holds the core in reset, streams words into imem, then releases it.
module imem_boot_ctrl #(
  parameter int ADDR_W        = 6,
  parameter int RELEASE_DELAY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  input  logic              go,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // one-hot state vector, bit index per state
  localparam int I_IDLE   = 0;
  localparam int I_LOAD   = 1;
  localparam int I_SETTLE = 2;
  localparam int I_RUN    = 3;
  localparam int I_ERR    = 4;

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_LOAD   = 5'b00010;
  localparam logic [4:0] S_SETTLE = 5'b00100;
  localparam logic [4:0] S_RUN    = 5'b01000;
  localparam logic [4:0] S_ERR    = 5'b10000;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [3:0] SETTLE_INIT =
    4'(RELEASE_DELAY - 1);

  logic [4:0]        state;
  logic [4:0]        state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W:0]   wc_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              accept;
  logic              at_top;

  assign in_ready   = state[I_LOAD];
  assign accept     = in_valid & in_ready;
  assign imem_we    = accept;
  assign imem_addr  = wr_ptr;
  assign imem_wdata = in_data;
  assign at_top     = (wr_ptr == PTR_MAX);

  // status bits come straight off state flops, so they are glitch-free
  assign core_rst_n = state[I_RUN];
  assign busy       = state[I_LOAD] | state[I_SETTLE];
  assign done       = state[I_RUN];
  assign error      = state[I_ERR];

  // next-state and datapath update decode
  always_comb begin
    state_nxt = state;
    ptr_nxt   = wr_ptr;
    wc_nxt    = word_count;
    cnt_nxt   = cnt;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (load_start) begin
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
          wc_nxt    = '0;
        end else if (go) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = SETTLE_INIT;
        end
      end
      state[I_LOAD]: begin
        if (accept) begin
          wc_nxt = word_count + 1'b1;
          // pointer saturates; the top slot is always the final write
          if (!at_top) begin
            ptr_nxt = wr_ptr + 1'b1;
          end
          if (in_last) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = SETTLE_INIT;
          end else if (at_top) begin
            state_nxt = S_ERR;
          end
        end
      end
      state[I_SETTLE]: begin
        if (load_start) begin
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
          wc_nxt    = '0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      state[I_RUN], state[I_ERR]: begin
        if (load_start) begin
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
          wc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      word_count <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= ptr_nxt;
      word_count <= wc_nxt;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot/program-load sequencer for the single-cycle RISC-V core.
- Holds the core in reset and streams program words from a valid/ready source into the instruction memory write port.
- Releases the core after a fixed settle delay, so programs load in-system.
- Sits between the top-level clock/reset and the core's reset input, beside the instruction ROM.

Parameters:
- ADDR_W, 6, instruction memory word-address width; depth DEPTH = 2**ADDR_W words.
- RELEASE_DELAY, 2, cycles spent in SETTLE between load end (or go) and core release; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle pulse requesting a program load.
- go  input  1  one-cycle pulse: start the core from existing memory contents without loading.
- in_valid  input  1  source has a program word.
- in_data  input  32  program word (instruction).
- in_last  input  1  qualifies the final word of a program.
- in_ready  output  1  controller accepts a word this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  instruction memory word address.
- imem_wdata  output  32  instruction memory write data.
- core_rst_n  output  1  active-low reset to the core; 1 = core runs.
- busy  output  1  high in LOAD or SETTLE.
- done  output  1  high in RUN.
- error  output  1  high in ERROR (program overflow).
- word_count  output  ADDR_W+1  number of words written by the most recent load.

Behaviour:
- States: IDLE, LOAD, SETTLE, RUN, ERROR. State is registered; RST=0 forces IDLE asynchronously.
- Reset values:
  - wr_ptr = 0, word_count = 0, settle counter = 0.
  - core_rst_n = 0, busy = 0, done = 0, error = 0, in_ready = 0, imem_we = 0.
- Registered outputs: core_rst_n, busy, done and error are decoded from the state register. core_rst_n = 1 only in RUN.
- Combinational outputs:
  - in_ready = (state == LOAD).
  - imem_we = in_valid & in_ready.
  - imem_addr = wr_ptr; imem_wdata = in_data. There is zero-cycle latency from an accepted beat to the memory write.
- IDLE:
  - load_start -> LOAD, with wr_ptr <= 0 and word_count <= 0.
  - Else go -> SETTLE, with counter <= RELEASE_DELAY-1.
  - When load_start and go are asserted together, load_start wins.
- LOAD:
  - Each accepted beat writes memory, wr_ptr <= wr_ptr+1 and word_count <= word_count+1.
  - Accepted beat with in_last=1 -> SETTLE, counter <= RELEASE_DELAY-1.
  - Accepted beat with wr_ptr == DEPTH-1 and in_last=0: the word is still written, then -> ERROR.
  - A beat with in_last=1 at DEPTH-1 is a legal full load and goes to SETTLE.
  - load_start and go are ignored in LOAD. in_valid=0 stalls indefinitely with no timeout.
- SETTLE:
  - The core is still held in reset. The counter decrements each cycle; at 0 -> RUN.
  - Total SETTLE dwell = RELEASE_DELAY cycles.
  - load_start -> LOAD (restart); go is ignored.
- RUN:
  - core_rst_n = 1 and done = 1.
  - load_start -> LOAD, re-asserting core reset on the next cycle. go is ignored.
- ERROR:
  - in_ready = 0, core held in reset, error = 1.
  - Only load_start -> LOAD exits; go is ignored.
  - word_count holds DEPTH.
- word_count is held outside LOAD.
- wr_ptr wrap-around never occurs: the ERROR transition prevents it.
- Asynchronous reset mid-LOAD aborts the load. Memory contents already written are retained; the controller returns to IDLE with the core in reset.
- in_data/in_last are don't-care when in_valid=0.

Test Plan:
- Reset then idle: hold RST=0 for 2 cycles, release, no stimulus for 5 cycles -> core_rst_n=0, in_ready=0, busy=0, done=0, error=0, word_count=0 throughout.
- Normal load: load_start, then stream 00500113, 00C00193, FF718393 (last) with in_valid continuous -> imem_we pulses at addr 0,1,2 with those data. word_count=3; busy=1 from LOAD entry through SETTLE. core_rst_n rises exactly RELEASE_DELAY cycles after the last-beat cycle (2 with default). done=1.
- Backpressure-free stalls: same 3 words with in_valid gaps of 1–3 cycles -> writes only on valid cycles, addresses still 0,1,2, no extra writes.
- Overflow: ADDR_W=2, stream 5 words, last on word 5 -> words 1–4 written to addr 0–3, then ERROR. error=1, in_ready=0, word_count=4, core_rst_n=0. A subsequent load_start with 1 word (last) -> RUN, error=0, word_count=1.
- Reload while running and go: in RUN, pulse load_start -> core_rst_n=0 on the next cycle, then the reload completes normally. Separately, from IDLE pulse go -> RUN after RELEASE_DELAY cycles with no imem_we. load_start and go in the same cycle -> LOAD.
- Reset mid-load: assert RST=0 after 2 of 4 beats -> immediately IDLE, core_rst_n=0, in_ready=0. After release, no further writes until load_start.
